fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the RV32 core family.
- Replaces the hard-wired PC register, PC+4 adder and next-PC mux with a fetch-PC state machine.
- Talks to instruction memory through a valid/ready request channel and an in-order response channel of arbitrary latency.
- Buffers fetched instructions with their PCs in a DEPTH-entry prefetch queue; drives a valid/ready stream to decode; supports branch/jump redirect with flush.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-path types: the fetch FSM state encoding and the counter/pointer width helpers.
// No logic of its own. Every fetch-side module imports it.
package cpu_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

  // The occupancy counters must hold the value DEPTH itself, so they need one bit more than a pointer.
  function automatic int cnt_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ptr_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: the imem request/response channels, the redirect input and the decode stream.
// master = fetch unit; slave = memory, branch unit and decode.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc, out_pc_plus4,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc, out_pc_plus4,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: a circular buffer with a registered head entry. An entry pushed into an empty queue is visible 1 cycle later.
// Backpressure: a push into a full queue is dropped unless a pop happens in the same cycle. A clear overrides both push and pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  input  logic                   clear,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = ptr_bits(DEPTH);
  localparam int CW = cnt_bits(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    remain;
  logic             do_push;
  logic             do_pop;

  assign do_pop     = pop && (count != '0);
  assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
  assign rd_ptr_nxt = rd_ptr + AW'(do_pop);
  assign remain     = count - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_dat <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_dat <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= remain + CW'(do_push);
      // If the pop leaves the queue empty, the entry being pushed becomes the head directly.
      if (remain == '0) begin
        if (do_push) begin
          head_dat <= push_dat;
        end
      end else begin
        head_dat <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: generates fetch PCs, issues imem requests by credit, queues responses and handles redirect/flush.
// Latency: a response reaches out_* 1 cycle later. Backpressure: requests stop once outstanding + queued reaches DEPTH.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int CW  = cnt_bits(DEPTH);
  localparam int CW1 = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q;
  logic [XLEN-1:0] rsp_pc_d;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   outstanding_d;
  logic [CW-1:0]   count;
  logic [CW1-1:0]  credit_used;
  logic            req_fire;
  logic            rsp_ok;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign credit_used        = {1'b0, outstanding_q} + {1'b0, count};
  assign bus.imem_req_valid = reset && (state_q == FETCH) && (credit_used < CW1'(DEPTH))
                              && !bus.redirect_valid;
  assign bus.imem_req_addr  = fetch_pc_q;

  assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
  // A response with nothing outstanding is spurious and must not underflow the counter.
  assign rsp_ok     = bus.imem_rsp_valid && (outstanding_q != '0);
  assign push       = rsp_ok && (state_q == FETCH) && !bus.redirect_valid;
  assign pop        = bus.out_valid && bus.out_ready;
  assign target_pc  = {bus.redirect_pc[XLEN-1:2], 2'b00};
  assign push_entry = '{pc: rsp_pc_q, instr: bus.imem_rsp_data};

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
    if (bus.redirect_valid) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      state_d    = (outstanding_d == '0) ? FETCH : FLUSH;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + XLEN'(INSTR_BYTES);
      end
      if ((state_q == FLUSH) && (outstanding_d == '0)) begin
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
    end
  end

  // A redirect clears the queue after any same-cycle pop has already been delivered.
  fetch_fifo #(
    .WIDTH(XLEN + 32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .clear    (bus.redirect_valid),
    .head_dat (head),
    .count    (count)
  );

  assign bus.out_valid    = (count != '0);
  assign bus.out_instr    = head.instr;
  assign bus.out_pc       = head.pc;
  assign bus.out_pc_plus4 = head.pc + XLEN'(INSTR_BYTES);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for streaming, backpressure and redirect, then hand sequences
// for flush, reset mid-operation and PC wraparound.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus ();
  fetch_unit_if #(.XLEN(32)) bus2 ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );
  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
    .clk(clk), .reset(rst2_n), .bus(bus2)
  );

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        rsp;
    logic [31:0] rsp_pc;
    logic        redir;
    logic [31:0] rpc;
    logic        ordy;
    logic        rv;
    logic [31:0] ra;
    logic        ov;
    logic [31:0] opc;
  } vec_t;

  vec_t vecs[24];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ pc;
  endfunction

  function automatic vec_t mk(input logic r, input logic rdy, input logic rsp, input logic [31:0] rsp_pc,
                              input logic redir, input logic [31:0] rpc, input logic ordy,
                              input logic rv, input logic [31:0] ra, input logic ov, input logic [31:0] opc);
    vec_t v;
    v.rst_n = r;  v.rdy = rdy;  v.rsp = rsp;  v.rsp_pc = rsp_pc;  v.redir = redir;  v.rpc = rpc;
    v.ordy = ordy;  v.rv = rv;  v.ra = ra;  v.ov = ov;  v.opc = opc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic rdy, input logic rsp, input logic [31:0] rsp_pc,
                       input logic redir, input logic [31:0] rpc, input logic ordy);
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? instr_of(rsp_pc) : 32'h0;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.out_ready      = ordy;
  endtask

  task automatic drive2(input logic rdy, input logic rsp, input logic [31:0] rsp_pc, input logic ordy);
    bus2.imem_req_ready = rdy;
    bus2.imem_rsp_valid = rsp;
    bus2.imem_rsp_data  = rsp ? instr_of(rsp_pc) : 32'h0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    bus2.out_ready      = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input logic [31:0] pc);
    chk({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, " out_pc"}, bus.out_pc, pc);
    chk({name, " out_instr"}, bus.out_instr, instr_of(pc));
    chk({name, " out_pc_plus4"}, bus.out_pc_plus4, pc + 32'd4);
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    drive2(1'b0, 1'b0, 32'h0, 1'b0);

    //           r  rdy rsp rsp_pc       red rpc          ordy  rv  ra           ov  opc
    vecs[0]  = mk(0, 0, 0, 32'h0,   0, 32'h0,   1,   0, 32'h0,   0, 32'h0);
    vecs[1]  = mk(1, 1, 0, 32'h0,   0, 32'h0,   1,   1, 32'h0,   0, 32'h0);
    vecs[2]  = mk(1, 1, 1, 32'h0,   0, 32'h0,   1,   1, 32'h4,   0, 32'h0);
    vecs[3]  = mk(1, 1, 1, 32'h4,   0, 32'h0,   1,   1, 32'h8,   1, 32'h0);
    vecs[4]  = mk(1, 1, 1, 32'h8,   0, 32'h0,   1,   1, 32'hC,   1, 32'h4);
    vecs[5]  = mk(1, 1, 1, 32'hC,   0, 32'h0,   0,   1, 32'h10,  1, 32'h8);
    vecs[6]  = mk(1, 1, 1, 32'h10,  0, 32'h0,   0,   1, 32'h14,  1, 32'h8);
    vecs[7]  = mk(1, 1, 1, 32'h14,  0, 32'h0,   0,   0, 32'h18,  1, 32'h8);
    vecs[8]  = mk(1, 1, 0, 32'h0,   0, 32'h0,   0,   0, 32'h18,  1, 32'h8);
    vecs[9]  = mk(1, 1, 0, 32'h0,   0, 32'h0,   1,   0, 32'h18,  1, 32'h8);
    vecs[10] = mk(1, 1, 0, 32'h0,   0, 32'h0,   0,   1, 32'h18,  1, 32'hC);
    vecs[11] = mk(1, 1, 1, 32'h18,  0, 32'h0,   0,   0, 32'h1C,  1, 32'hC);
    vecs[12] = mk(1, 1, 0, 32'h0,   1, 32'h103, 1,   0, 32'h1C,  1, 32'hC);
    vecs[13] = mk(1, 1, 0, 32'h0,   0, 32'h0,   1,   1, 32'h100, 0, 32'h0);
    vecs[14] = mk(1, 0, 1, 32'h100, 0, 32'h0,   1,   1, 32'h104, 0, 32'h0);
    vecs[15] = mk(1, 0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h104, 1, 32'h100);
    vecs[16] = mk(1, 0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h104, 0, 32'h0);
    vecs[17] = mk(1, 1, 0, 32'h0,   0, 32'h0,   1,   1, 32'h104, 0, 32'h0);
    vecs[18] = mk(1, 1, 1, 32'h104, 1, 32'h200, 1,   0, 32'h108, 0, 32'h0);
    vecs[19] = mk(1, 1, 0, 32'h0,   0, 32'h0,   1,   1, 32'h200, 0, 32'h0);
    vecs[20] = mk(1, 0, 1, 32'h200, 0, 32'h0,   0,   1, 32'h204, 0, 32'h0);
    vecs[21] = mk(1, 0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h204, 1, 32'h200);
    vecs[22] = mk(1, 0, 1, 32'h204, 0, 32'h0,   1,   1, 32'h204, 0, 32'h0);
    vecs[23] = mk(1, 0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h204, 0, 32'h0);

    next_cycle();
    for (int i = 0; i < 24; i++) begin
      rst_n = vecs[i].rst_n;
      drive(vecs[i].rdy, vecs[i].rsp, vecs[i].rsp_pc, vecs[i].redir, vecs[i].rpc, vecs[i].ordy);
      #3;
      chk($sformatf("v%0d req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].rv));
      chk($sformatf("v%0d req_addr", i), bus.imem_req_addr, vecs[i].ra);
      chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
      if (vecs[i].ov) chk_head($sformatf("v%0d", i), vecs[i].opc);
      if (!vecs[i].rst_n) begin
        chk($sformatf("v%0d reset out_pc", i), bus.out_pc, 32'h0);
        chk($sformatf("v%0d reset out_instr", i), bus.out_instr, 32'h0);
        chk($sformatf("v%0d reset out_pc_plus4", i), bus.out_pc_plus4, 32'h4);
      end
      next_cycle();
    end

    // Three requests in flight, redirected twice while flushing; all three responses must be dropped.
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 32'h0, 0, 32'h0, 1);  #3;
      chk($sformatf("flush issue%0d valid", k), 32'(bus.imem_req_valid), 32'd1);
      chk($sformatf("flush issue%0d addr", k), bus.imem_req_addr, 32'h204 + 32'(4 * k));
      next_cycle();
    end
    drive(1, 0, 32'h0, 1, 32'h303, 1);  #3;
    chk("flush redirect req_valid", 32'(bus.imem_req_valid), 32'd0);
    next_cycle();
    drive(1, 0, 32'h0, 0, 32'h0, 1);  #3;
    chk("flush state req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("flush target addr", bus.imem_req_addr, 32'h300);
    next_cycle();
    drive(1, 1, 32'h204, 0, 32'h0, 1);  #3;
    chk("flush rsp1 req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("flush rsp1 out_valid", 32'(bus.out_valid), 32'd0);
    next_cycle();
    drive(1, 0, 32'h0, 1, 32'h103, 1);  #3;
    chk("flush re-redirect req_valid", 32'(bus.imem_req_valid), 32'd0);
    next_cycle();
    drive(1, 1, 32'h208, 0, 32'h0, 1);  #3;
    chk("flush rsp2 req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("flush rsp2 addr", bus.imem_req_addr, 32'h100);
    chk("flush rsp2 out_valid", 32'(bus.out_valid), 32'd0);
    next_cycle();
    drive(1, 0, 32'h0, 0, 32'h0, 1);  #3;
    chk("flush gap req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("flush gap out_valid", 32'(bus.out_valid), 32'd0);
    next_cycle();
    drive(1, 1, 32'h20C, 0, 32'h0, 1);  #3;
    chk("flush last rsp req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("flush last rsp out_valid", 32'(bus.out_valid), 32'd0);
    next_cycle();
    drive(1, 0, 32'h0, 0, 32'h0, 1);  #3;
    chk("flush resume req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("flush resume addr", bus.imem_req_addr, 32'h100);
    chk("flush resume out_valid", 32'(bus.out_valid), 32'd0);
    next_cycle();
    drive(0, 1, 32'h100, 0, 32'h0, 1);  #3;
    chk("flush new rsp out_valid", 32'(bus.out_valid), 32'd0);
    next_cycle();
    drive(0, 0, 32'h0, 0, 32'h0, 1);  #3;
    chk_head("flush first", 32'h100);
    next_cycle();

    // Reset asserted with two requests outstanding and two entries queued.
    drive(1, 0, 32'h0, 0, 32'h0, 0);  #3;
    chk("prerst addr0", bus.imem_req_addr, 32'h104);
    next_cycle();
    drive(1, 1, 32'h104, 0, 32'h0, 0);  #3;
    chk("prerst addr1", bus.imem_req_addr, 32'h108);
    next_cycle();
    drive(1, 1, 32'h108, 0, 32'h0, 0);  #3;
    chk("prerst addr2", bus.imem_req_addr, 32'h10C);
    next_cycle();
    drive(1, 0, 32'h0, 0, 32'h0, 0);  #3;
    chk("prerst addr3", bus.imem_req_addr, 32'h110);
    next_cycle();
    drive(1, 0, 32'h0, 0, 32'h0, 0);  #3;
    chk("prerst credit stall", 32'(bus.imem_req_valid), 32'd0);
    chk_head("prerst", 32'h104);
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("midrst req_addr", bus.imem_req_addr, 32'h0);
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst out_pc", bus.out_pc, 32'h0);
    chk("midrst out_instr", bus.out_instr, 32'h0);
    chk("midrst out_pc_plus4", bus.out_pc_plus4, 32'h4);
    next_cycle();
    rst_n = 1'b1;
    drive(1, 0, 32'h0, 0, 32'h0, 1);  #3;
    chk("postrst req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("postrst req_addr", bus.imem_req_addr, 32'h0);
    chk("postrst out_valid", 32'(bus.out_valid), 32'd0);
    next_cycle();
    drive(0, 1, 32'h0, 0, 32'h0, 1);  #3;
    chk("postrst rsp out_valid", 32'(bus.out_valid), 32'd0);
    next_cycle();
    drive(0, 0, 32'h0, 0, 32'h0, 1);  #3;
    chk_head("postrst first", 32'h0);
    next_cycle();

    // Second instance: fetch PC wraps past the top of the address space.
    chk("wrap reset req_valid", 32'(bus2.imem_req_valid), 32'd0);
    chk("wrap reset addr", bus2.imem_req_addr, 32'hFFFF_FFF8);
    rst2_n = 1'b1;
    drive2(1, 0, 32'h0, 1);  #3;
    chk("wrap addr0", bus2.imem_req_addr, 32'hFFFF_FFF8);
    chk("wrap valid0", 32'(bus2.imem_req_valid), 32'd1);
    next_cycle();
    drive2(1, 1, 32'hFFFF_FFF8, 1);  #3;
    chk("wrap addr1", bus2.imem_req_addr, 32'hFFFF_FFFC);
    next_cycle();
    drive2(1, 1, 32'hFFFF_FFFC, 1);  #3;
    chk("wrap addr2", bus2.imem_req_addr, 32'h0000_0000);
    chk("wrap out0 pc", bus2.out_pc, 32'hFFFF_FFF8);
    chk("wrap out0 plus4", bus2.out_pc_plus4, 32'hFFFF_FFFC);
    next_cycle();
    drive2(0, 0, 32'h0, 1);  #3;
    chk("wrap out1 valid", 32'(bus2.out_valid), 32'd1);
    chk("wrap out1 pc", bus2.out_pc, 32'hFFFF_FFFC);
    chk("wrap out1 instr", bus2.out_instr, instr_of(32'hFFFF_FFFC));
    chk("wrap out1 plus4", bus2.out_pc_plus4, 32'h0000_0000);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
